spi_slave_word: RTL and testbench
=================================

Name: spi_slave_word

Overview:
- Parametrised SPI slave that moves whole words of WORD_WIDTH bits per SPI word.
- Supports all four SPI modes, MSB- or LSB-first ordering, and back-to-back words while CS_n stays low.
- Fully synchronous to i_Clk: SCLK, CS_n and MOSI are oversampled through synchronisers, so the SPI logic has no separate clock domain.
- Sits between an external SPI master and fabric logic. TX and RX use valid/ready handshakes, and status pulses report underrun, overrun and aborted words.

Parameters:
- SPI_MODE, 0, SPI mode 0..3 (CPOL = mode[1], CPHA = mode[0]).
- WORD_WIDTH, 8, bits per SPI word, legal 2..32.
- MSB_FIRST, 1, 1 = MSB shifted first on both MISO and MOSI; 0 = LSB first.
- TX_FILL, 0, WORD_WIDTH-bit value sent when no TX word is available.

Ports:
- i_Clk  in  1  fabric clock, at least 8x the SCLK frequency.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_TX_Valid  in  1  TX word offered.
- i_TX_Data  in  WORD_WIDTH  word to transmit.
- o_TX_Ready  out  1  holding register empty; a word is accepted when i_TX_Valid & o_TX_Ready.
- o_RX_Valid  out  1  o_RX_Data holds an unread word.
- o_RX_Data  out  WORD_WIDTH  received word.
- i_RX_Ready  in  1  consumer accepts o_RX_Data.
- o_TX_Underrun  out  1  1-cycle pulse: TX_FILL was loaded.
- o_RX_Overrun  out  1  1-cycle pulse: a completed word was dropped.
- o_Frame_Err  out  1  1-cycle pulse: CS_n rose mid-word.
- o_Busy  out  1  frame active.
- i_SPI_Clk  in  1  SCLK.
- o_SPI_MISO  out  1  MISO, high-Z when the frame is inactive.
- i_SPI_MOSI  in  1  MOSI.
- i_SPI_CS_n  in  1  chip select, active-low.

Behaviour:
- Reset values:
  - o_TX_Ready=1; o_RX_Valid=0; o_RX_Data=0; all status pulses 0; o_Busy=0; MISO high-Z.
  - Holding register empty; counters 0.
  - SCLK synchroniser reset to CPOL, CS_n synchroniser to 1, MOSI synchroniser to 0.
- Synchronisation: 2-FF synchronisers on SCLK, CS_n and MOSI, plus one history stage for edge detection.
  - Leading edge = SCLK leaving CPOL; trailing edge = returning to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.
- Frame start: detected CS_n falling edge sets the frame-active flag (o_Busy=1) and clears the bit counter.
  - CPHA=0: load the TX shifter immediately.
  - CPHA=1: set load_pending instead.
  - Edges are ignored unless the flag is set. If reset is released while CS_n is already low, the block waits for the next CS_n falling edge.
- Sample edge:
  - Shift MOSI into the RX shifter (toward LSB if MSB_FIRST, else toward MSB); bit counter +1.
  - At count WORD_WIDTH-1: word complete. Counter wraps to 0 and load_pending is set.
- RX output, on the cycle after word complete:
  - If o_RX_Valid=0, or (o_RX_Valid & i_RX_Ready) in that cycle: o_RX_Data updates and o_RX_Valid=1.
  - Otherwise the new word is dropped, the old word is kept, and o_RX_Overrun pulses.
  - o_RX_Valid clears on i_RX_Ready when no new word arrives.
- TX load rules:
  - A load takes the holding register if full; the holding register clears and o_TX_Ready becomes 1.
  - If the holding register is empty but i_TX_Valid=1 in the same cycle: bypass, load i_TX_Data, no underrun.
  - Otherwise load TX_FILL and pulse o_TX_Underrun.
- Shift edge:
  - If load_pending: perform a load and clear load_pending.
  - Else: shift the TX shifter by one bit.
- MISO: driven from the first-out bit of the TX shifter (MSB or LSB per MSB_FIRST) while the frame is active.
- Timing budget: MISO changes within 4 i_Clk of the SCLK pin edge, and o_RX_Valid rises 4 i_Clk after the sample-edge pin transition. The master must allow at least 4 i_Clk between CS_n fall and the first SCLK edge.
- Frame end: detected CS_n rising edge clears the flag (o_Busy=0), the counter and load_pending; MISO goes high-Z.
  - If the counter is not 0, the partial word is discarded and o_Frame_Err pulses.
  - Any unused holding word stays for the next frame.
- Reset mid-frame: everything returns to reset values immediately, with no status pulses.

Test Plan:
- Mode 0, WORD_WIDTH=8: TX 0xA5 preloaded; master sends 0x3C in one frame -> MISO bits 1,0,1,0,0,1,0,1; o_RX_Data=0x3C with a 1-cycle o_RX_Valid; no status pulses.
- Mode 3, WORD_WIDTH=16: TX 0x1234 only; master sends 0xBEEF,0xCAFE with CS_n held low -> MISO 0x1234 then TX_FILL 0x0000; one o_TX_Underrun pulse at the second load; RX words 0xBEEF then 0xCAFE.
- Mode 1: i_RX_Ready=0 across two received words 0x11,0x22 -> o_RX_Data stays 0x11; one o_RX_Overrun pulse; then i_RX_Ready=1 clears o_RX_Valid.
- Mode 2, MSB_FIRST=0: master sends 0x01 LSB-first -> o_RX_Data=0x01; TX 0x80 appears on MISO as seven 0s then a 1.
- Mode 0: CS_n rises after 5 bits -> o_Frame_Err pulses once, no o_RX_Valid; the next full frame receives correctly.
- Mode 0: assert i_Rst_L=0 mid-word, release while CS_n is still low -> SCLK edges ignored, MISO high-Z; operation resumes normally after a new CS_n fall.

Source files
------------

// File: rtl/spi_slave_word_if.sv
// Fabric-side handshake bundle for spi_slave_word: TX and RX valid/ready
// channels, status pulses and the frame-busy flag. The SPI pins stay on the
// module itself because they face the board, not the fabric.
interface spi_slave_word_if #(
    parameter int unsigned WORD_WIDTH = 8
);
    logic                  i_TX_Valid;
    logic [WORD_WIDTH-1:0] i_TX_Data;
    logic                  o_TX_Ready;
    logic                  o_RX_Valid;
    logic [WORD_WIDTH-1:0] o_RX_Data;
    logic                  i_RX_Ready;
    logic                  o_TX_Underrun;
    logic                  o_RX_Overrun;
    logic                  o_Frame_Err;
    logic                  o_Busy;

    // View from inside the SPI slave.
    modport slave (
        input  i_TX_Valid, i_TX_Data, i_RX_Ready,
        output o_TX_Ready, o_RX_Valid, o_RX_Data,
        output o_TX_Underrun, o_RX_Overrun, o_Frame_Err, o_Busy
    );

    // View from the fabric logic feeding and draining the slave.
    modport master (
        output i_TX_Valid, i_TX_Data, i_RX_Ready,
        input  o_TX_Ready, o_RX_Valid, o_RX_Data,
        input  o_TX_Underrun, o_RX_Overrun, o_Frame_Err, o_Busy
    );
endinterface

// File: rtl/spi_slave_word.sv
// Word-oriented SPI slave. SCLK, CS_n and MOSI are oversampled in the i_Clk
// domain, so all SPI activity is seen as edges of synchronised signals.
// TX words go through a one-entry holding register into a shifter; RX words
// are presented on a valid/ready output register.
module spi_slave_word #(
    parameter int unsigned           SPI_MODE   = 0,
    parameter int unsigned           WORD_WIDTH = 8,
    parameter bit                    MSB_FIRST  = 1'b1,
    parameter logic [WORD_WIDTH-1:0] TX_FILL    = '0
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    spi_slave_word_if.slave  bus,
    input  logic             i_SPI_Clk,
    output logic             o_SPI_MISO,
    input  logic             i_SPI_MOSI,
    input  logic             i_SPI_CS_n
);
    localparam bit          CPOL  = SPI_MODE[1];
    localparam bit          CPHA  = SPI_MODE[0];
    localparam int unsigned CNT_W = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // Synchroniser and edge-history stages.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    // live_q marks that the first stage holds a real pin sample; armed_q
    // requires CS_n to have been seen high before a falling edge counts, so
    // a reset released with CS_n already low does not start a frame.
    logic live_q, armed_q;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  load_pend_q, load_pend_d;
    logic [WORD_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  done_q, done_d;
    logic [WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WORD_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [WORD_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  underrun_q, underrun_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  do_load;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise;

    assign lead_edge   = (sclk_prev_q == CPOL) && (sclk_sync_q != CPOL);
    assign trail_edge  = (sclk_prev_q != CPOL) && (sclk_sync_q == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign cs_fall     = armed_q && cs_prev_q && !cs_sync_q;
    assign cs_rise     = !cs_prev_q && cs_sync_q;

    // Two-flop synchronisers on the SPI inputs plus one history stage.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_meta_q <= CPOL;
            sclk_sync_q <= CPOL;
            sclk_prev_q <= CPOL;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            live_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // value from before this edge; blocking would collapse the chain.
            sclk_meta_q <= i_SPI_Clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= i_SPI_CS_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= i_SPI_MOSI;
            mosi_sync_q <= mosi_meta_q;
            live_q      <= 1'b1;
            armed_q     <= armed_q | (live_q & cs_meta_q);
        end
    end

    // Next-state logic: frame tracking, shifters, TX holding register, RX output.
    always_comb begin
        // NOTE: every _d gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        load_pend_d = load_pend_q;
        rx_shift_d  = rx_shift_q;
        done_d      = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        underrun_d  = 1'b0;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        do_load     = 1'b0;

        // Fabric offers a TX word while the holding register is empty.
        if (bus.i_TX_Valid && !hold_full_q) begin
            hold_d      = bus.i_TX_Data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    bit_cnt_d   = '0;
                    load_pend_d = CPHA;
                    do_load     = !CPHA;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    load_pend_d = 1'b0;
                    frame_err_d = (bit_cnt_q != '0);
                end else begin
                    if (sample_edge) begin
                        if (MSB_FIRST) begin
                            rx_shift_d = {rx_shift_q[WORD_WIDTH-2:0], mosi_sync_q};
                        end else begin
                            rx_shift_d = {mosi_sync_q, rx_shift_q[WORD_WIDTH-1:1]};
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d   = '0;
                            load_pend_d = 1'b1;
                            done_d      = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (load_pend_q) begin
                            do_load     = 1'b1;
                            load_pend_d = 1'b0;
                        end else if (MSB_FIRST) begin
                            tx_shift_d = {tx_shift_q[WORD_WIDTH-2:0], 1'b0};
                        end else begin
                            tx_shift_d = {1'b0, tx_shift_q[WORD_WIDTH-1:1]};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shifter load: holding register, else same-cycle bypass, else fill.
        if (do_load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else if (bus.i_TX_Valid) begin
                tx_shift_d  = bus.i_TX_Data;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = TX_FILL;
                underrun_d = 1'b1;
            end
        end

        // A completed word lands in the output register one cycle later.
        if (done_q) begin
            if (!rx_valid_q || bus.i_RX_Ready) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && bus.i_RX_Ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // State registers for the frame logic.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            load_pend_q <= 1'b0;
            rx_shift_q  <= '0;
            done_q      <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            load_pend_q <= load_pend_d;
            rx_shift_q  <= rx_shift_d;
            done_q      <= done_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.o_TX_Ready    = !hold_full_q;
    assign bus.o_RX_Valid    = rx_valid_q;
    assign bus.o_RX_Data     = rx_data_q;
    assign bus.o_TX_Underrun = underrun_q;
    assign bus.o_RX_Overrun  = overrun_q;
    assign bus.o_Frame_Err   = frame_err_q;
    assign bus.o_Busy        = (state_q == ST_ACTIVE);

    // MISO carries the first-out bit of the shifter and is released between frames.
    assign o_SPI_MISO = (state_q == ST_ACTIVE)
                        ? (MSB_FIRST ? tx_shift_q[WORD_WIDTH-1] : tx_shift_q[0])
                        : 1'bz;
endmodule

// File: tb/tb_spi_slave_word.sv
// Directed bench for spi_slave_word. Instance k runs SPI mode k:
// k=0,1 are 8-bit MSB-first, k=2 is 8-bit LSB-first, k=3 is 16-bit MSB-first.
// A shared SCLK/MOSI pair is driven by a small master model; each instance
// has its own chip select, so only the selected one takes part in a frame.
module tb_spi_slave_word;
    localparam int HALF = 8;  // i_Clk cycles per SCLK half period

    logic clk = 1'b0;
    logic rst_n;
    logic sclk, mosi;
    logic [3:0]  cs_n, tx_valid, rx_ready;
    logic [31:0] tx_data [4];

    wire  [3:0]  tx_ready, rx_valid, underrun, overrun, ferr, busy, miso;
    wire  [31:0] rx_data [4];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int GW = (gi == 3) ? 16 : 8;
        wire miso_w;

        spi_slave_word_if #(.WORD_WIDTH(GW)) sif ();

        spi_slave_word #(
            .SPI_MODE   (gi),
            .WORD_WIDTH (GW),
            .MSB_FIRST  (gi != 2)
        ) u_dut (
            .i_Clk      (clk),
            .i_Rst_L    (rst_n),
            .bus        (sif),
            .i_SPI_Clk  (sclk),
            .o_SPI_MISO (miso_w),
            .i_SPI_MOSI (mosi),
            .i_SPI_CS_n (cs_n[gi])
        );

        assign sif.i_TX_Valid = tx_valid[gi];
        assign sif.i_TX_Data  = tx_data[gi][GW-1:0];
        assign sif.i_RX_Ready = rx_ready[gi];
        assign tx_ready[gi]   = sif.o_TX_Ready;
        assign rx_valid[gi]   = sif.o_RX_Valid;
        assign rx_data[gi]    = 32'(sif.o_RX_Data);
        assign underrun[gi]   = sif.o_TX_Underrun;
        assign overrun[gi]    = sif.o_RX_Overrun;
        assign ferr[gi]       = sif.o_Frame_Err;
        assign busy[gi]       = sif.o_Busy;
        assign miso[gi]       = miso_w;
    end

    // Event counters and RX word log, sampled mid-cycle.
    int n_under [4] = '{default: 0};
    int n_over  [4] = '{default: 0};
    int n_ferr  [4] = '{default: 0};
    int n_rx    [4] = '{default: 0};
    int n_vcyc  [4] = '{default: 0};
    logic [31:0] rx_log [4][4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (underrun[i]) n_under[i] <= n_under[i] + 1;
            if (overrun[i])  n_over[i]  <= n_over[i] + 1;
            if (ferr[i])     n_ferr[i]  <= n_ferr[i] + 1;
            if (rx_valid[i]) n_vcyc[i]  <= n_vcyc[i] + 1;
            if (rx_valid[i] && rx_ready[i]) begin
                rx_log[i][n_rx[i] & 3] <= rx_data[i];
                n_rx[i]                <= n_rx[i] + 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Snapshot of the counters for one instance, to check per-test deltas.
    int b_under, b_over, b_ferr, b_rx, b_vcyc;
    task automatic snap(input int s);
        b_under = n_under[s];
        b_over  = n_over[s];
        b_ferr  = n_ferr[s];
        b_rx    = n_rx[s];
        b_vcyc  = n_vcyc[s];
    endtask

    function automatic logic [31:0] rx_nth(input int s, input int k);
        return rx_log[s][k & 3];
    endfunction

    task automatic set_mode(input int s);
        sclk = ((s & 2) != 0);
        wait_clk(4);
    endtask

    task automatic tx_push(input int s, input logic [31:0] data);
        for (int k = 0; k < 100 && !tx_ready[s]; k++) wait_clk(1);
        check("tx_ready_before_push", 32'(tx_ready[s]), 32'd1);
        tx_valid[s] = 1'b1;
        tx_data[s]  = data;
        wait_clk(1);
        tx_valid[s] = 1'b0;
    endtask

    task automatic cs_low(input int s);
        cs_n[s] = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high(input int s);
        wait_clk(HALF);
        cs_n[s] = 1'b1;
        wait_clk(HALF);
    endtask

    // Master side of nbits SPI bits; seq collects MISO with the first bit
    // ending up most significant.
    task automatic xfer(input int s, input logic [31:0] word, input int nbits,
                        output logic [31:0] seq);
        bit cpol = ((s & 2) != 0);
        bit cpha = ((s & 1) != 0);
        int w    = (s == 3) ? 16 : 8;
        int idx;
        seq = '0;
        for (int b = 0; b < nbits; b++) begin
            idx = (s != 2) ? (w - 1 - b) : b;
            if (!cpha) begin
                mosi = word[idx];
                wait_clk(HALF);
                seq  = {seq[30:0], miso[s]};
                sclk = ~cpol;
                wait_clk(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = word[idx];
                wait_clk(HALF);
                seq  = {seq[30:0], miso[s]};
                sclk = cpol;
                wait_clk(HALF);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] seq, seq2;
        rst_n    = 1'b0;
        sclk     = 1'b0;
        mosi     = 1'b0;
        cs_n     = 4'hF;
        tx_valid = 4'h0;
        rx_ready = 4'hF;
        for (int i = 0; i < 4; i++) tx_data[i] = '0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);

        // Reset state.
        check("rst_tx_ready", 32'(tx_ready), 32'hF);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_data0", rx_data[0], 32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_pulses",   32'(n_under[0] + n_over[0] + n_ferr[0]), 32'd0);

        // Mode 0: 0xA5 out, 0x3C in. A second word is put in the holding
        // register once 0xA5 is in the shifter, so the trailing edge after the
        // last sample has a word to load and no underrun is raised.
        set_mode(0);
        tx_push(0, 32'hA5);
        snap(0);
        cs_low(0);
        check("m0_busy", 32'(busy[0]), 32'd1);
        tx_push(0, 32'h96);
        xfer(0, 32'h3C, 8, seq);
        cs_high(0);
        check("m0_miso_bits", seq, 32'h0000_00A5);
        check("m0_rx_data",   rx_nth(0, n_rx[0] - 1), 32'h3C);
        check("m0_rx_words",  32'(n_rx[0] - b_rx), 32'd1);
        check("m0_valid_cyc", 32'(n_vcyc[0] - b_vcyc), 32'd1);
        check("m0_status",    32'((n_under[0] - b_under) + (n_over[0] - b_over) +
                                  (n_ferr[0] - b_ferr)), 32'd0);
        check("m0_idle_busy", 32'(busy[0]), 32'd0);

        // Mode 3, 16-bit: one TX word for a two-word frame.
        set_mode(3);
        tx_push(3, 32'h1234);
        snap(3);
        cs_low(3);
        xfer(3, 32'hBEEF, 16, seq);
        xfer(3, 32'hCAFE, 16, seq2);
        cs_high(3);
        check("m3_miso_w0",   seq,  32'h1234);
        check("m3_miso_w1",   seq2, 32'h0000);
        check("m3_underrun",  32'(n_under[3] - b_under), 32'd1);
        check("m3_rx_words",  32'(n_rx[3] - b_rx), 32'd2);
        check("m3_rx_w0",     rx_nth(3, b_rx),     32'hBEEF);
        check("m3_rx_w1",     rx_nth(3, b_rx + 1), 32'hCAFE);

        // Mode 1: consumer stalled across two words.
        set_mode(1);
        rx_ready[1] = 1'b0;
        snap(1);
        cs_low(1);
        xfer(1, 32'h11, 8, seq);
        xfer(1, 32'h22, 8, seq);
        cs_high(1);
        check("m1_valid_held", 32'(rx_valid[1]), 32'd1);
        check("m1_data_kept",  rx_data[1], 32'h11);
        check("m1_overrun",    32'(n_over[1] - b_over), 32'd1);
        rx_ready[1] = 1'b1;
        wait_clk(2);
        check("m1_valid_clr",  32'(rx_valid[1]), 32'd0);

        // Mode 2, LSB first.
        set_mode(2);
        tx_push(2, 32'h80);
        snap(2);
        cs_low(2);
        xfer(2, 32'h01, 8, seq);
        cs_high(2);
        check("m2_miso_bits", seq, 32'h0000_0001);
        check("m2_rx_data",   rx_nth(2, n_rx[2] - 1), 32'h01);
        check("m2_rx_words",  32'(n_rx[2] - b_rx), 32'd1);

        // Mode 0: aborted word, then a clean one.
        set_mode(0);
        snap(0);
        cs_low(0);
        xfer(0, 32'hFF, 5, seq);
        cs_high(0);
        check("abort_frame_err", 32'(n_ferr[0] - b_ferr), 32'd1);
        check("abort_no_rx",     32'(n_rx[0] - b_rx), 32'd0);
        cs_low(0);
        xfer(0, 32'hC3, 8, seq);
        cs_high(0);
        check("after_abort_rx",   rx_nth(0, n_rx[0] - 1), 32'hC3);
        check("after_abort_ferr", 32'(n_ferr[0] - b_ferr), 32'd1);

        // Mode 0: reset mid-word, released with CS_n still low.
        cs_low(0);
        xfer(0, 32'hFF, 3, seq);
        snap(0);
        rst_n = 1'b0;
        wait_clk(3);
        check("midrst_busy",     32'(busy[0]),     32'd0);
        check("midrst_tx_ready", 32'(tx_ready[0]), 32'd1);
        check("midrst_rx_valid", 32'(rx_valid[0]), 32'd0);
        check("midrst_rx_data",  rx_data[0],       32'h0);
        rst_n = 1'b1;
        wait_clk(4);
        xfer(0, 32'hAA, 8, seq);
        check("ignored_busy",   32'(busy[0]), 32'd0);
        check("ignored_rx",     32'(n_rx[0] - b_rx), 32'd0);
        check("ignored_status", 32'((n_under[0] - b_under) + (n_over[0] - b_over) +
                                    (n_ferr[0] - b_ferr)), 32'd0);
        cs_high(0);
        check("ignored_rise_ferr", 32'(n_ferr[0] - b_ferr), 32'd0);
        cs_low(0);
        check("resume_busy", 32'(busy[0]), 32'd1);
        xfer(0, 32'h5A, 8, seq);
        cs_high(0);
        check("resume_rx", rx_nth(0, n_rx[0] - 1), 32'h5A);
        check("resume_rx_words", 32'(n_rx[0] - b_rx), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
